vx_mem_responder: RTL and testbench

Memory-side responder for the Vortex external memory interface: accepts the request channel a top-level Vortex instance drives (valid/rw/byteen/addr/data/tag/ready) and returns tagged read responses on the response channel. It is backed by an on-chip word-addressed SRAM, returns responses after a fixed pipeline latency with in-order delivery, and applies credit-based backpressure so that no accepted read is ever dropped. It is used in simulation testbenches and small FPGA builds in place of an external DRAM controller.

---
 rtl/vx_mem_responder.sv | 148 ++++++++++++++
 tb/tb_vx_mem_responder.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/vx_mem_responder.sv
// ============================================================================
// vx_mem_responder : SRAM-backed responder for the Vortex memory request bus
// Revision 1.0
// ============================================================================
`default_nettype none

module vx_mem_responder #(
    parameter int DATA_WIDTH     = 512,
    parameter int ADDR_WIDTH     = 26,
    parameter int TAG_WIDTH      = 8,
    parameter int MEM_LINES      = 1024,
    parameter int LATENCY        = 4,
    parameter int RSP_QUEUE_SIZE = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    i_mem_req_valid,
    input  logic                    i_mem_req_rw,
    input  logic [DATA_WIDTH/8-1:0] i_mem_req_byteen,
    input  logic [ADDR_WIDTH-1:0]   i_mem_req_addr,
    input  logic [DATA_WIDTH-1:0]   i_mem_req_data,
    input  logic [TAG_WIDTH-1:0]    i_mem_req_tag,
    output logic                    o_mem_req_ready,
    output logic                    o_mem_rsp_valid,
    output logic [DATA_WIDTH-1:0]   o_mem_rsp_data,
    output logic [TAG_WIDTH-1:0]    o_mem_rsp_tag,
    input  logic                    i_mem_rsp_ready,
    output logic                    o_busy
);

    localparam int c_BYTES = DATA_WIDTH / 8;
    localparam int c_IDX_W = $clog2(MEM_LINES);
    localparam int c_PTR_W = $clog2(RSP_QUEUE_SIZE);
    localparam int c_CNT_W = c_PTR_W + 1;
    localparam logic [c_CNT_W-1:0] c_CREDITS = c_CNT_W'(RSP_QUEUE_SIZE);

    logic                  r_ready_en;
    logic [c_CNT_W-1:0]    r_outstanding;
    logic                  w_req_fire;
    logic                  w_rd_fire;
    logic                  w_wr_fire;
    logic                  w_rsp_fire;
    logic [c_IDX_W-1:0]    w_idx;
    logic                  w_unused_addr;

    logic [DATA_WIDTH-1:0] r_mem [MEM_LINES];

    logic [LATENCY-1:0]    r_pipe_valid;
    logic [DATA_WIDTH-1:0] r_pipe_data [LATENCY];
    logic [TAG_WIDTH-1:0]  r_pipe_tag  [LATENCY];

    logic [DATA_WIDTH-1:0] r_fifo_data [RSP_QUEUE_SIZE];
    logic [TAG_WIDTH-1:0]  r_fifo_tag  [RSP_QUEUE_SIZE];
    logic [c_CNT_W-1:0]    r_wr_ptr;
    logic [c_CNT_W-1:0]    r_rd_ptr;
    logic                  w_fifo_push;

    // Credits cover pipeline plus queue, so the FIFO can never overflow.
    assign o_mem_req_ready = r_ready_en && (r_outstanding < c_CREDITS);
    assign w_req_fire      = i_mem_req_valid && o_mem_req_ready;
    assign w_rd_fire       = w_req_fire && !i_mem_req_rw;
    assign w_wr_fire       = w_req_fire && i_mem_req_rw;
    assign w_rsp_fire      = o_mem_rsp_valid && i_mem_rsp_ready;
    assign w_idx           = i_mem_req_addr[c_IDX_W-1:0];
    assign w_unused_addr   = ^i_mem_req_addr[ADDR_WIDTH-1:c_IDX_W];
    assign o_busy          = (r_outstanding != '0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ready_en <= 1'b0;
        end else begin
            r_ready_en <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr_fire) begin
            for (int b = 0; b < c_BYTES; b++) begin
                if (i_mem_req_byteen[b]) begin
                    r_mem[w_idx][b*8 +: 8] <= i_mem_req_data[b*8 +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pipe_valid <= '0;
        end else begin
            r_pipe_valid[0] <= w_rd_fire;
            for (int k = 1; k < LATENCY; k++) begin
                r_pipe_valid[k] <= r_pipe_valid[k-1];
            end
        end
    end

    // Stage 0 is the synchronous SRAM read; a write fired last cycle is visible.
    always_ff @(posedge clk) begin
        r_pipe_data[0] <= r_mem[w_idx];
        r_pipe_tag[0]  <= i_mem_req_tag;
        for (int k = 1; k < LATENCY; k++) begin
            r_pipe_data[k] <= r_pipe_data[k-1];
            r_pipe_tag[k]  <= r_pipe_tag[k-1];
        end
    end

    assign w_fifo_push = r_pipe_valid[LATENCY-1];

    always_ff @(posedge clk) begin
        if (w_fifo_push) begin
            r_fifo_data[r_wr_ptr[c_PTR_W-1:0]] <= r_pipe_data[LATENCY-1];
            r_fifo_tag[r_wr_ptr[c_PTR_W-1:0]]  <= r_pipe_tag[LATENCY-1];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_fifo_push) begin
                r_wr_ptr <= r_wr_ptr + c_CNT_W'(1);
            end
            if (w_rsp_fire) begin
                r_rd_ptr <= r_rd_ptr + c_CNT_W'(1);
            end
        end
    end

    assign o_mem_rsp_valid = (r_wr_ptr != r_rd_ptr);
    assign o_mem_rsp_data  = o_mem_rsp_valid ? r_fifo_data[r_rd_ptr[c_PTR_W-1:0]] : '0;
    assign o_mem_rsp_tag   = o_mem_rsp_valid ? r_fifo_tag[r_rd_ptr[c_PTR_W-1:0]]  : '0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_outstanding <= '0;
        end else begin
            case ({w_rd_fire, w_rsp_fire})
                2'b10:   r_outstanding <= r_outstanding + c_CNT_W'(1);
                2'b01:   r_outstanding <= r_outstanding - c_CNT_W'(1);
                default: r_outstanding <= r_outstanding;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_vx_mem_responder.sv
// ============================================================================
// tb_vx_mem_responder : scoreboard bench for vx_mem_responder
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_vx_mem_responder;

    localparam int DW  = 512;
    localparam int AW  = 26;
    localparam int TW  = 8;
    localparam int ML  = 1024;
    localparam int LAT = 4;
    localparam int QS  = 8;
    localparam int NB  = DW / 8;
    localparam int IW  = $clog2(ML);

    logic          clk;
    logic          reset;
    logic          req_valid;
    logic          req_rw;
    logic [NB-1:0] req_byteen;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_data;
    logic [TW-1:0] req_tag;
    logic          req_ready;
    logic          rsp_valid;
    logic [DW-1:0] rsp_data;
    logic [TW-1:0] rsp_tag;
    logic          rsp_ready;
    logic          busy;

    vx_mem_responder #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TAG_WIDTH(TW),
        .MEM_LINES(ML), .LATENCY(LAT), .RSP_QUEUE_SIZE(QS)
    ) u_dut (
        .clk              (clk),
        .reset            (reset),
        .i_mem_req_valid  (req_valid),
        .i_mem_req_rw     (req_rw),
        .i_mem_req_byteen (req_byteen),
        .i_mem_req_addr   (req_addr),
        .i_mem_req_data   (req_data),
        .i_mem_req_tag    (req_tag),
        .o_mem_req_ready  (req_ready),
        .o_mem_rsp_valid  (rsp_valid),
        .o_mem_rsp_data   (rsp_data),
        .o_mem_rsp_tag    (rsp_tag),
        .i_mem_rsp_ready  (rsp_ready),
        .o_busy           (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int            n_tests = 0;
    int            n_fail  = 0;
    int            n_ticks = 0;
    int            n_rsp   = 0;
    logic          fired;
    logic [DW-1:0] last_rsp_data;
    logic [DW-1:0] model_mem [ML];
    logic [DW-1:0] exp_data [$];
    logic [TW-1:0] exp_tag  [$];

    task automatic chk(input string name, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Called at a falling edge with inputs set; resolves fires of the next rising edge.
    task automatic tick();
        logic [IW-1:0] idx;
        #1;
        fired = 1'b0;
        idx   = req_addr[IW-1:0];
        if (req_valid && req_ready) begin
            fired = 1'b1;
            if (req_rw) begin
                for (int b = 0; b < NB; b++) begin
                    if (req_byteen[b]) model_mem[idx][b*8 +: 8] = req_data[b*8 +: 8];
                end
            end else begin
                exp_data.push_back(model_mem[idx]);
                exp_tag.push_back(req_tag);
            end
        end
        if (rsp_valid && rsp_ready) begin
            n_rsp++;
            last_rsp_data = rsp_data;
            if (exp_tag.size() == 0) begin
                chk("unexpected_rsp", DW'(1), DW'(0));
            end else begin
                chk("rsp_tag", DW'(rsp_tag), DW'(exp_tag.pop_front()));
                chk("rsp_data", rsp_data, exp_data.pop_front());
            end
        end
        n_ticks++;
        @(negedge clk);
    endtask

    task automatic do_req(input logic rw, input logic [AW-1:0] a, input logic [DW-1:0] d,
                          input logic [NB-1:0] be, input logic [TW-1:0] t, output int waits);
        req_valid = 1'b1; req_rw = rw; req_addr = a; req_data = d; req_byteen = be; req_tag = t;
        waits = 0;
        tick();
        while (!fired && waits < 50) begin
            waits++;
            tick();
        end
        if (!fired) chk("req_timeout", DW'(0), DW'(1));
        req_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        rsp_ready = 1'b1;
        while ((exp_tag.size() != 0 || rsp_valid) && n < 100) begin
            tick();
            n++;
        end
        chk("drain_empty", DW'(exp_tag.size()), DW'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1);
    end

    initial begin
        int            w;
        int            lat;
        int            sum;
        int            base;
        int            stale;
        logic [7:0]    bv;
        logic [DW-1:0] pat;

        reset = 1'b1; req_valid = 1'b0; req_rw = 1'b0; req_addr = '0;
        req_data = '0; req_byteen = '0; req_tag = '0; rsp_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_ready", DW'(req_ready), DW'(0));
        chk("rst_valid", DW'(rsp_valid), DW'(0));
        chk("rst_busy", DW'(busy), DW'(0));
        chk("rst_data", rsp_data, DW'(0));
        chk("rst_tag", DW'(rsp_tag), DW'(0));
        reset = 1'b0;
        #1 chk("ready_first_cycle", DW'(req_ready), DW'(0));
        @(negedge clk);
        chk("ready_second_cycle", DW'(req_ready), DW'(1));

        // Full write then read with latency measurement
        do_req(1'b1, 26'h10, {NB{8'hA5}}, '1, '0, w);
        chk("t1_busy_after_write", DW'(busy), DW'(0));
        rsp_ready = 1'b1;
        do_req(1'b0, 26'h10, '0, '0, 8'h3C, w);
        chk("t1_busy_while", DW'(busy), DW'(1));
        lat = 0;
        while (!rsp_valid && lat < 20) begin
            tick();
            lat++;
        end
        chk("t1_latency", DW'(lat), DW'(LAT));
        chk("t1_data", rsp_data, {NB{8'hA5}});
        chk("t1_tag", DW'(rsp_tag), DW'(8'h3C));
        tick();
        chk("t1_busy_done", DW'(busy), DW'(0));
        chk("t1_valid_done", DW'(rsp_valid), DW'(0));

        // Partial byte-enable write
        do_req(1'b1, 26'd5, '0, '1, '0, w);
        do_req(1'b1, 26'd5, '1, NB'(8'h0F), '0, w);
        do_req(1'b0, 26'd5, '0, '0, 8'h55, w);
        drain();
        chk("partial_data", last_rsp_data, {{(NB-4){8'h00}}, {4{8'hFF}}});

        // Aliasing plus read-after-write on the next cycle
        pat = {16{32'hC0FFEE07}};
        do_req(1'b1, 26'(ML + 7), pat, '1, '0, w);
        do_req(1'b0, 26'd7, '0, '0, 8'h77, w);
        drain();
        chk("alias_raw_data", last_rsp_data, pat);

        for (int i = 0; i < 10; i++) begin
            bv = 8'h20 + 8'(i);
            do_req(1'b1, 26'(256 + i), {NB{bv}}, '1, '0, w);
        end

        // Back-to-back throughput
        rsp_ready = 1'b1;
        base = n_rsp;
        n_ticks = 0;
        sum = 0;
        for (int i = 0; i < 8; i++) begin
            do_req(1'b0, 26'(256 + i), '0, '0, 8'(8'h40 + i), w);
            sum += w;
        end
        chk("tput_no_stall", DW'(sum), DW'(0));
        while (n_rsp < base + 8 && n_ticks < 100) tick();
        chk("tput_ticks", DW'(n_ticks), DW'(9 + LAT));
        drain();

        // Backpressure: only QS reads accepted while responses are blocked
        rsp_ready = 1'b0;
        base = n_rsp;
        sum = 0;
        for (int i = 0; i < QS; i++) begin
            do_req(1'b0, 26'(256 + i), '0, '0, 8'(i), w);
            sum += w;
        end
        chk("bp_first8_no_stall", DW'(sum), DW'(0));
        req_valid = 1'b1; req_rw = 1'b0; req_addr = 26'(256 + 8); req_tag = 8'd8;
        sum = 0;
        repeat (6) begin
            tick();
            if (fired) sum++;
        end
        chk("bp_blocked", DW'(sum), DW'(0));
        chk("bp_ready_low", DW'(req_ready), DW'(0));
        chk("bp_busy", DW'(busy), DW'(1));
        chk("bp_valid", DW'(rsp_valid), DW'(1));

        // One response fire at the limit; the pending read goes in next cycle
        rsp_ready = 1'b1;
        tick();
        chk("sim_no_accept", DW'(fired), DW'(0));
        rsp_ready = 1'b0;
        tick();
        chk("sim_accept_next", DW'(fired), DW'(1));
        req_valid = 1'b0;
        chk("sim_ready_low_again", DW'(req_ready), DW'(0));

        rsp_ready = 1'b1;
        do_req(1'b0, 26'(256 + 9), '0, '0, 8'd9, w);
        drain();
        chk("bp_rsp_count", DW'(n_rsp - base), DW'(10));
        chk("bp_busy_done", DW'(busy), DW'(0));

        // Asynchronous reset with reads in flight
        rsp_ready = 1'b0;
        for (int i = 0; i < 5; i++) do_req(1'b0, 26'(256 + i), '0, '0, 8'(8'h80 + i), w);
        chk("mid_valid_before", DW'(rsp_valid), DW'(1));
        #2 reset = 1'b1;
        #1;
        chk("mid_rst_valid", DW'(rsp_valid), DW'(0));
        chk("mid_rst_busy", DW'(busy), DW'(0));
        chk("mid_rst_ready", DW'(req_ready), DW'(0));
        exp_data.delete();
        exp_tag.delete();
        repeat (2) @(negedge clk);
        reset = 1'b0;
        rsp_ready = 1'b1;
        stale = 0;
        repeat (10) begin
            if (rsp_valid) stale++;
            tick();
        end
        chk("mid_no_stale", DW'(stale), DW'(0));
        chk("mid_busy_after", DW'(busy), DW'(0));
        do_req(1'b0, 26'h10, '0, '0, 8'h3D, w);
        drain();
        chk("mid_sram_kept", last_rsp_data, {NB{8'hA5}});

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
